mem_bus_responder: RTL and testbench

Memory-side responder for the processor's external bus: it answers the address/data transactions that the microcoded controller initiates. It latches the bus address and services reads and writes with a configurable number of wait states. It returns read data, such as instruction words and load operands, on a registered output paired with a one-cycle `ready` pulse. It also provides a preload port so benches and boot logic can fill memory before the core runs.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_responder_mem_array.sv | 29 ++
 rtl/mem_bus_responder.sv | 133 +++++++++++++
 tb/tb_mem_bus_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side bus responder: FSM encoding,
// read/write polarity and wait-counter width.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bus_responder_mem_array.sv
// Single-port synchronous RAM, N x 2**A, one write port and a registered
// read that only updates when rd_en is high.
module mem_array #(
  parameter int N = 16,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic         rd_en,
  input  logic [A-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata
);

  logic [N-1:0] mem_reg [2**A];
  logic [N-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    if (rd_en) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: latches the bus address, serves reads/writes
// with W wait states, and shares the RAM port with a preload path.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int N = 16,
  parameter int A = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] addr_in,
  input  logic         addr_en,
  input  logic [N-1:0] data_in,
  input  logic         data_en,
  input  logic         rw,
  input  logic         ld_en,
  input  logic [A-1:0] ld_addr,
  input  logic [N-1:0] ld_data,
  output logic [N-1:0] dout,
  output logic         ready,
  output logic         err,
  output logic         busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [N-1:0]     addr_q;
  logic [N-1:0]     xaddr;
  logic [N-1:0]     wdata_reg;
  logic             rw_reg;
  logic             zero_reg;
  logic             accept;
  logic             oor;

  logic             ram_we;
  logic             ram_rd;
  logic [A-1:0]     ram_addr;
  logic [N-1:0]     ram_wdata;
  logic [N-1:0]     ram_rdata;

  assign oor = |(xaddr >> A);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (data_en && !ld_en) begin
          accept     = 1'b1;
          state_next = (W == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      xaddr     <= '0;
      wdata_reg <= '0;
      rw_reg    <= RW_READ;
      cnt_reg   <= '0;
      zero_reg  <= 1'b1;
    end else begin
      if (addr_en) begin
        addr_q <= addr_in;
      end
      if (accept) begin
        xaddr     <= addr_en ? addr_in : addr_q;
        wdata_reg <= data_in;
        rw_reg    <= rw;
        cnt_reg   <= CNT_W'(W);
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      // An out-of-range read forces dout to zero until the next read.
      if (state_reg == ST_ACCESS && rw_reg == RW_READ) begin
        zero_reg <= oor;
      end
    end
  end

  // Bus access owns the port in ACCESS; preload only gets it in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_rd    = 1'b0;
    ram_addr  = ld_addr;
    ram_wdata = ld_data;
    if (state_reg == ST_ACCESS) begin
      ram_addr  = xaddr[A-1:0];
      ram_wdata = wdata_reg;
      ram_we    = (rw_reg == RW_WRITE) && !oor;
      ram_rd    = (rw_reg == RW_READ) && !oor;
    end else if (state_reg == ST_IDLE && ld_en) begin
      ram_we = 1'b1;
    end
  end

  mem_array #(
    .N(N),
    .A(A)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .rd_en (ram_rd),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign dout  = zero_reg ? '0 : ram_rdata;
  assign ready = (state_reg == ST_DONE);
  assign err   = (state_reg == ST_DONE) && oor;
  assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomised bench for mem_bus_responder: three instances (W=1, W=0, W=3)
// checked against a word-array model of memory, address register and dout.
module tb_mem_bus_responder;

  logic clk;
  logic rst_n;

  logic [15:0] addr_in [3];
  logic        addr_en [3];
  logic [15:0] data_in [3];
  logic        data_en [3];
  logic        rw      [3];
  logic        ld_en   [3];
  logic [7:0]  ld_addr [3];
  logic [15:0] ld_data [3];
  logic [15:0] dout    [3];
  logic        ready   [3];
  logic        err     [3];
  logic        busy    [3];

  logic [15:0] mem_m     [3][256];
  logic [15:0] addr_q_m  [3];
  logic [15:0] last_dout [3];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_bus_responder #(
      .N(16),
      .A(8),
      .W(gi == 0 ? 1 : (gi == 1 ? 0 : 3))
    ) dut (
      .clk     (clk),
      .rst     (rst_n),
      .addr_in (addr_in[gi]),
      .addr_en (addr_en[gi]),
      .data_in (data_in[gi]),
      .data_en (data_en[gi]),
      .rw      (rw[gi]),
      .ld_en   (ld_en[gi]),
      .ld_addr (ld_addr[gi]),
      .ld_data (ld_data[gi]),
      .dout    (dout[gi]),
      .ready   (ready[gi]),
      .err     (err[gi]),
      .busy    (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wv(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int d, input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    @(posedge clk); #1;
    ld_en[d] = 1'b0;
    mem_m[d][a] = v;
  endtask

  task automatic set_addr(input int d, input logic [15:0] a);
    @(negedge clk);
    addr_en[d] = 1'b1; addr_in[d] = a;
    @(posedge clk); #1;
    addr_en[d] = 1'b0;
    addr_q_m[d] = a;
  endtask

  // Counts edges until ready; optionally scrambles inputs the DUT must ignore.
  task automatic wait_ready(input int d, input bit toggle, output int n);
    n = 0;
    while (n < 40) begin
      if (toggle) begin
        rw[d]      = 1'($urandom);
        data_in[d] = 16'($urandom);
        ld_en[d]   = 1'($urandom);
        ld_addr[d] = 8'($urandom);
        ld_data[d] = 16'($urandom);
        addr_en[d] = ($urandom_range(0, 3) == 0);
        addr_in[d] = 16'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (addr_en[d]) addr_q_m[d] = addr_in[d];
      if (ready[d]) break;
    end
    ld_en[d]   = 1'b0;
    addr_en[d] = 1'b0;
  endtask

  task automatic do_txn(input int d, input logic rd, input logic [15:0] a,
                        input logic [15:0] wd, input bit use_ae,
                        input bit with_ld, input logic [7:0] la, input logic [15:0] lv);
    int n;
    logic [15:0] eff;
    logic        oor;
    @(negedge clk);
    data_en[d] = 1'b1; rw[d] = rd; data_in[d] = wd;
    addr_en[d] = use_ae;
    addr_in[d] = use_ae ? a : 16'($urandom);
    if (with_ld) begin
      ld_en[d] = 1'b1; ld_addr[d] = la; ld_data[d] = lv;
      @(posedge clk); #1;
      mem_m[d][la] = lv;
      if (addr_en[d]) addr_q_m[d] = addr_in[d];
      check("ld_defers_accept", busy[d], 0);
      ld_en[d] = 1'b0; addr_en[d] = 1'b0;
    end
    eff = addr_en[d] ? addr_in[d] : addr_q_m[d];
    @(posedge clk); #1;
    if (addr_en[d]) addr_q_m[d] = addr_in[d];
    addr_en[d] = 1'b0;
    check("busy_after_accept", busy[d], 1);
    wait_ready(d, 1'b1, n);
    data_en[d] = 1'b0;
    oor = (eff[15:8] != 8'h00);
    if (rd) begin
      last_dout[d] = oor ? 16'h0000 : mem_m[d][eff[7:0]];
    end else if (!oor) begin
      mem_m[d][eff[7:0]] = wd;
    end
    check("latency", n, wv(d) + 1);
    check("err", err[d], oor);
    check("dout", dout[d], last_dout[d]);
    $display("txn dut%0d %s addr=%04h wdata=%04h lat=%0d err=%0b dout=%04h",
             d, rd ? "RD" : "WR", eff, wd, n, err[d], dout[d]);
    @(posedge clk); #1;
    check("ready_one_cycle", ready[d], 0);
    check("idle_after_done", busy[d], 0);
  endtask

  initial begin
    int n1, n2;
    logic [15:0] ra;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      addr_in[d] = '0; addr_en[d] = 1'b0; data_in[d] = '0; data_en[d] = 1'b0;
      rw[d] = 1'b0; ld_en[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
      addr_q_m[d] = '0; last_dout[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_dout", dout[d], 0);
      check("rst_ready", ready[d], 0);
      check("rst_err", err[d], 0);
      check("rst_busy", busy[d], 0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Give every word a known value so any read has a defined expectation.
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        ld_en[d] = 1'b1; ld_addr[d] = 8'(a); ld_data[d] = 16'($urandom);
        mem_m[d][a] = ld_data[d];
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) ld_en[d] = 1'b0;

    // Preload then W=1 read through the latched address.
    preload(0, 8'h05, 16'hA5C3);
    set_addr(0, 16'h0005);
    do_txn(0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("plan_read_a5c3", dout[0], 16'hA5C3);

    // W=0 write then read back.
    do_txn(1, 1'b0, 16'h0010, 16'h1234, 1'b1, 1'b0, 8'h00, 16'h0000);
    do_txn(1, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("plan_read_1234", dout[1], 16'h1234);

    // Out of range write/read, then the in-range alias is untouched.
    do_txn(0, 1'b0, 16'h0105, 16'hDEAD, 1'b1, 1'b0, 8'h00, 16'h0000);
    do_txn(0, 1'b1, 16'h0105, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    do_txn(0, 1'b1, 16'h0005, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("alias_unchanged", dout[0], 16'hA5C3);

    // addr_en on the accept edge overrides addr_q.
    preload(0, 8'h03, 16'h3333);
    preload(0, 8'h07, 16'h7777);
    set_addr(0, 16'h0003);
    do_txn(0, 1'b1, 16'h0007, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("addr_en_wins", dout[0], 16'h7777);

    // Preload wins over a same-cycle request, which follows one edge later.
    do_txn(0, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    check("ld_then_read", dout[0], 16'hBEEF);

    // W=3 write/read with inputs scrambled mid-flight.
    do_txn(2, 1'b0, 16'h0042, 16'h4242, 1'b1, 1'b0, 8'h00, 16'h0000);
    do_txn(2, 1'b1, 16'h0042, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);

    // Reset while a W=3 write sits in WAIT: the write must never land.
    @(negedge clk);
    addr_en[2] = 1'b1; addr_in[2] = 16'h0042; data_en[2] = 1'b1;
    rw[2] = 1'b0; data_in[2] = 16'h9999;
    @(posedge clk); #1;
    addr_en[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    data_en[2] = 1'b0;
    check("rst_mid_dout", dout[2], 0);
    check("rst_mid_ready", ready[2], 0);
    check("rst_mid_err", err[2], 0);
    check("rst_mid_busy", busy[2], 0);
    for (int d = 0; d < 3; d++) begin
      addr_q_m[d] = '0; last_dout[d] = '0;
    end
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_no_ready", ready[2], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    do_txn(2, 1'b1, 16'h0042, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("aborted_write", dout[2], 16'h4242);

    // Back-to-back reads on W=1 with data_en held high throughout.
    @(negedge clk);
    addr_en[0] = 1'b1; addr_in[0] = 16'h0007; data_en[0] = 1'b1; rw[0] = 1'b1;
    @(posedge clk); #1;
    addr_q_m[0] = 16'h0007;
    addr_en[0] = 1'b0;
    wait_ready(0, 1'b0, n1);
    check("b2b_first_lat", n1, 2);
    check("b2b_first_dout", dout[0], mem_m[0][7]);
    addr_en[0] = 1'b1; addr_in[0] = 16'h0020;
    $display("txn dut0 RD addr=0007 b2b first lat=%0d dout=%04h", n1, dout[0]);
    wait_ready(0, 1'b0, n2);
    data_en[0] = 1'b0;
    last_dout[0] = mem_m[0][8'h20];
    check("b2b_spacing", n2, 4);
    check("b2b_second_dout", dout[0], mem_m[0][8'h20]);
    $display("txn dut0 RD addr=0020 b2b second gap=%0d dout=%04h", n2, dout[0]);
    @(posedge clk); #1;
    check("b2b_ready_drop", ready[0], 0);

    // Random traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 25; t++) begin
        if ($urandom_range(0, 7) == 0)
          ra = {8'($urandom_range(1, 255)), 8'($urandom)};
        else
          ra = {8'h00, 4'h0, 4'($urandom)};
        if ($urandom_range(0, 3) == 0) set_addr(d, ra);
        do_txn(d, 1'($urandom), ra, 16'($urandom), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 5) == 0), {4'h0, 4'($urandom)}, 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
